// File: rtl/mig_memtest_pkg.sv
// Shared types, command codes and the word-level data pattern for the MIG app-interface memory test.
package mig_memtest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CAL,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_t;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    // n is the global 32-bit word index: burst * words_per_burst + word.
    function automatic logic [31:0] pat(input logic [31:0] n, input logic [31:0] seed);
        return n ^ seed;
    endfunction

endpackage

// File: rtl/mig_app_memtest_if.sv
// MIG 7-series user (app) interface bundle; master is the traffic generator, slave is the controller side.
interface mig_app_if #(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 256
);
    logic [ADDR_W-1:0]   app_addr;
    logic [2:0]          app_cmd;
    logic                app_en;
    logic                app_rdy;
    logic [DATA_W-1:0]   app_wdf_data;
    logic                app_wdf_wren;
    logic                app_wdf_end;
    logic [DATA_W/8-1:0] app_wdf_mask;
    logic                app_wdf_rdy;
    logic [DATA_W-1:0]   app_rd_data;
    logic                app_rd_data_valid;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/memtest_pattern_gen.sv
// Expands a burst index into the full DATA_W address-derived pattern, word 0 in the LSBs.
module memtest_pattern_gen
    import mig_memtest_pkg::*;
#(
    parameter int          DATA_W = 256,
    parameter logic [31:0] SEED   = 32'hA5A5_5A5A
) (
    input  logic [31:0]       burst,
    output logic [DATA_W-1:0] data
);
    localparam int WORDS = DATA_W / 32;

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        assign data[gi*32 +: 32] = pat(burst * 32'(WORDS) + 32'(gi), SEED);
    end

endmodule

// File: rtl/mig_app_memtest.sv
// Write-then-read-back DDR3 traffic generator/checker on the MIG app interface.
// Optional no-progress watchdog enabled by defining MIG_APP_MEMTEST_TIMEOUT_EN.
module mig_app_memtest
    import mig_memtest_pkg::*;
#(
    parameter int          ADDR_W      = 29,
    parameter int          DATA_W      = 256,
    parameter int          NUM_BURSTS  = 1024,
    parameter int          ADDR_STEP   = 8,
    parameter logic [31:0] SEED        = 32'hA5A5_5A5A,
    parameter int          TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              calib_done,
    mig_app_if.master         app,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              timeout
);
    localparam int                CNT_W = $clog2(NUM_BURSTS + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_BURSTS - 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(NUM_BURSTS);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(ADDR_STEP);

    state_t             state_reg;
    logic [CNT_W-1:0]   cmd_cnt_reg, wdf_cnt_reg, ret_cnt_reg;
    logic [ADDR_W-1:0]  addr_reg, ret_addr_reg;
    logic [2:0]         cmd_reg;
    logic               en_reg, wren_reg;
    logic [DATA_W-1:0]  wr_pat, exp_pat;
    logic               cmd_hs, wdf_hs, rd_hs;

    memtest_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_wr_pat (
        .burst (32'(wdf_cnt_reg)),
        .data  (wr_pat)
    );

    memtest_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_exp_pat (
        .burst (32'(ret_cnt_reg)),
        .data  (exp_pat)
    );

    assign cmd_hs = en_reg & app.app_rdy;
    assign wdf_hs = wren_reg & app.app_wdf_rdy;
    assign rd_hs  = (state_reg == ST_READ) & app.app_rd_data_valid;

    assign app.app_addr     = addr_reg;
    assign app.app_cmd      = cmd_reg;
    assign app.app_en       = en_reg;
    assign app.app_wdf_data = wr_pat;
    assign app.app_wdf_wren = wren_reg;
    assign app.app_wdf_end  = 1'b1;
    assign app.app_wdf_mask = '0;

`ifdef MIG_APP_MEMTEST_TIMEOUT_EN
    logic [15:0] wd_reg;
    logic        timeout_reg;
    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cmd_cnt_reg    <= '0;
            wdf_cnt_reg    <= '0;
            ret_cnt_reg    <= '0;
            addr_reg       <= '0;
            ret_addr_reg   <= '0;
            cmd_reg        <= CMD_WRITE;
            en_reg         <= 1'b0;
            wren_reg       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
`ifdef MIG_APP_MEMTEST_TIMEOUT_EN
            wd_reg         <= '0;
            timeout_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    // pass/fail settle one cycle after DONE entry, once err_count is final
                    if (state_reg == ST_DONE) begin
                        pass <= (err_count == 16'd0) & ~timeout;
                        fail <= (err_count != 16'd0) | timeout;
                    end
                    if (start) begin
                        state_reg      <= ST_WAIT_CAL;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        fail           <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        cmd_cnt_reg    <= '0;
                        wdf_cnt_reg    <= '0;
                        ret_cnt_reg    <= '0;
                        ret_addr_reg   <= '0;
                        addr_reg       <= '0;
`ifdef MIG_APP_MEMTEST_TIMEOUT_EN
                        timeout_reg    <= 1'b0;
`endif
                    end
                end
                ST_WAIT_CAL: begin
                    if (calib_done) begin
                        state_reg <= ST_WRITE;
                        cmd_reg   <= CMD_WRITE;
                        en_reg    <= 1'b1;
                        wren_reg  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // command and data streams run independently; either may lead
                    if (cmd_hs) begin
                        cmd_cnt_reg <= cmd_cnt_reg + 1'b1;
                        addr_reg    <= addr_reg + STEP;
                        if (cmd_cnt_reg == LAST) en_reg <= 1'b0;
                    end
                    if (wdf_hs) begin
                        wdf_cnt_reg <= wdf_cnt_reg + 1'b1;
                        if (wdf_cnt_reg == LAST) wren_reg <= 1'b0;
                    end
                    if (cmd_cnt_reg == FULL && wdf_cnt_reg == FULL) begin
                        state_reg   <= ST_READ;
                        cmd_reg     <= CMD_READ;
                        en_reg      <= 1'b1;
                        addr_reg    <= '0;
                        cmd_cnt_reg <= '0;
                    end
                end
                ST_READ: begin
                    if (cmd_hs) begin
                        cmd_cnt_reg <= cmd_cnt_reg + 1'b1;
                        addr_reg    <= addr_reg + STEP;
                        if (cmd_cnt_reg == LAST) en_reg <= 1'b0;
                    end
                    if (rd_hs) begin
                        ret_cnt_reg  <= ret_cnt_reg + 1'b1;
                        ret_addr_reg <= ret_addr_reg + STEP;
                        if (app.app_rd_data != exp_pat) begin
                            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                            if (err_count == 16'd0) first_err_addr <= ret_addr_reg;
                        end
                        if (ret_cnt_reg == LAST) begin
                            state_reg <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            en_reg    <= 1'b0;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

`ifdef MIG_APP_MEMTEST_TIMEOUT_EN
            // watchdog: any handshake counts as progress
            if (state_reg == ST_WRITE || state_reg == ST_READ) begin
                if (cmd_hs || wdf_hs || rd_hs) begin
                    wd_reg <= '0;
                end else if (wd_reg == 16'(TIMEOUT_CYC - 1)) begin
                    wd_reg      <= '0;
                    timeout_reg <= 1'b1;
                    state_reg   <= ST_DONE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    en_reg      <= 1'b0;
                    wren_reg    <= 1'b0;
                end else begin
                    wd_reg <= wd_reg + 16'd1;
                end
            end else begin
                wd_reg <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mig_app_memtest.sv
// Scoreboard bench for mig_app_memtest: randomized app-interface memory model, expected
// command/data streams and per-run results queued at start, checked by monitors on handshakes.
module tb_mig_app_memtest;
    import mig_memtest_pkg::*;

    localparam int          AW   = 29;
    localparam int          DW   = 256;
    localparam int          NB   = 4;
    localparam logic [31:0] SEED = 32'hA5A5_5A5A;

    logic clk = 1'b0;
    logic rst, start, calib_done;
    logic busy, done, pass, fail, timeout;
    logic [15:0] err_count;
    logic [AW-1:0] first_err_addr;

    mig_app_if #(.ADDR_W(AW), .DATA_W(DW)) app_if ();

    mig_app_memtest #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_BURSTS(NB), .ADDR_STEP(8), .SEED(SEED), .TIMEOUT_CYC(100)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .calib_done(calib_done), .app(app_if.master),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .err_count(err_count),
        .first_err_addr(first_err_addr), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference pattern straight from the arithmetic definition
    function automatic logic [DW-1:0] ref_data(input int n);
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = 32'(n * (DW / 32) + k) ^ SEED;
        return d;
    endfunction

    typedef struct {
        logic [15:0]   err;
        logic [AW-1:0] addr;
        logic          pass_v;
        logic          fail_v;
        logic          to_v;
    } res_t;

    res_t            res_q[$];
    logic [AW-1:0]   exp_wa_q[$], exp_ra_q[$];
    logic [DW-1:0]   exp_wd_q[$];
    logic [AW-1:0]   wa_q[$], rd_pend[$];
    logic [DW-1:0]   wd_q[$];
    logic [DW-1:0]   mem [int unsigned];
    logic [NB-1:0]   flip_mask = '0;
    int  stall_pct = 0;
    bit  hold_cmd = 0, hold_ret = 0, calib_raised = 0;
    int  wcmd_run = 0, wdf_run = 0, rcmd_run = 0, last_hs = 0, done_events = 0;

    // Memory model + stream scoreboard: readies chosen at negedge, so app_x & rdy here is the
    // handshake that the coming posedge will take.
    bit            cmd_stalled = 0, wdf_stalled = 0;
    logic [AW-1:0] held_addr;
    logic [2:0]    held_cmd;
    logic [DW-1:0] held_data;
    always @(negedge clk) begin
        if (rst) begin
            wa_q.delete(); wd_q.delete(); rd_pend.delete();
            cmd_stalled = 0; wdf_stalled = 0;
            app_if.app_rdy = 0; app_if.app_wdf_rdy = 0; app_if.app_rd_data_valid = 0;
        end else begin
            if (cmd_stalled) begin
                check("cmd_hold_en", app_if.app_en, 1'b1);
                check("cmd_hold_addr", app_if.app_addr, held_addr);
                check("cmd_hold_cmd", app_if.app_cmd, held_cmd);
            end
            if (wdf_stalled) begin
                check("wdf_hold_wren", app_if.app_wdf_wren, 1'b1);
                check("wdf_hold_data", app_if.app_wdf_data, held_data);
            end
            app_if.app_rdy     = (hold_cmd && wdf_run < 3) ? 1'b0 : ($urandom_range(99) >= stall_pct);
            app_if.app_wdf_rdy = ($urandom_range(99) >= stall_pct);
            cmd_stalled = app_if.app_en && !app_if.app_rdy;
            wdf_stalled = app_if.app_wdf_wren && !app_if.app_wdf_rdy;
            held_addr = app_if.app_addr; held_cmd = app_if.app_cmd; held_data = app_if.app_wdf_data;

            app_if.app_rd_data_valid = 0;
            if (!hold_ret && rd_pend.size() > 0 && $urandom_range(1) == 1) begin
                logic [AW-1:0] a;
                logic [DW-1:0] d;
                a = rd_pend.pop_front();
                d = mem.exists(int'(a)) ? mem[int'(a)] : '0;
                if ((a >> 3) < NB && flip_mask[a >> 3]) d[5] = ~d[5];
                app_if.app_rd_data = d;
                app_if.app_rd_data_valid = 1;
                last_hs = cyc;
            end

            if (app_if.app_en && app_if.app_rdy) begin
                last_hs = cyc;
                if (app_if.app_cmd == CMD_WRITE) begin
                    wcmd_run++;
                    if (exp_wa_q.size() > 0) check("wr_cmd_addr", app_if.app_addr, exp_wa_q.pop_front());
                    wa_q.push_back(app_if.app_addr);
                end else begin
                    rcmd_run++;
                    check("rd_cmd_code", app_if.app_cmd, CMD_READ);
                    if (exp_ra_q.size() > 0) check("rd_cmd_addr", app_if.app_addr, exp_ra_q.pop_front());
                    rd_pend.push_back(app_if.app_addr);
                end
            end
            if (app_if.app_wdf_wren && app_if.app_wdf_rdy) begin
                last_hs = cyc;
                if (wdf_run == 1) check("burst1_word0", app_if.app_wdf_data[31:0], 32'd8 ^ SEED);
                wdf_run++;
                if (exp_wd_q.size() > 0) check("wr_data", app_if.app_wdf_data, exp_wd_q.pop_front());
                wd_q.push_back(app_if.app_wdf_data);
            end
            while (wa_q.size() > 0 && wd_q.size() > 0) mem[int'(wa_q.pop_front())] = wd_q.pop_front();
        end
    end

    // Result monitor: compares status one cycle after done rises (pass/fail settle then).
    bit done_q = 0, chk_pend = 0;
    always @(negedge clk) begin
        if (rst) begin
            done_q = 0; chk_pend = 0;
        end else begin
            if (!calib_raised && busy) check("no_cmd_before_calib", app_if.app_en | app_if.app_wdf_wren, 1'b0);
            if (chk_pend) begin
                chk_pend = 0;
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got done with no run pending, expected none");
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("err_count", err_count, r.err);
                    check("first_err_addr", first_err_addr, r.addr);
                    check("pass", pass, r.pass_v);
                    check("fail", fail, r.fail_v);
                    check("timeout", timeout, r.to_v);
                    check("busy_at_done", busy, 1'b0);
                end
            end
            if (done && !done_q) begin
                chk_pend = 1;
                done_events++;
            end
            done_q = done;
        end
    end

    // Queue expected streams and the expected outcome, derived from the flip mask.
    task automatic begin_run(input logic [NB-1:0] flips, input bit expect_to);
        res_t r;
        flip_mask = flips;
        wcmd_run = 0; wdf_run = 0; rcmd_run = 0;
        r.err = 0; r.addr = 0;
        for (int n = 0; n < NB; n++) begin
            exp_wa_q.push_back(AW'(n * 8));
            exp_ra_q.push_back(AW'(n * 8));
            exp_wd_q.push_back(ref_data(n));
        end
        for (int n = NB - 1; n >= 0; n--) if (flips[n]) begin
            r.err++;
            r.addr = AW'(n * 8);
        end
        if (expect_to) begin
            r.err = 0; r.addr = 0;
        end
        r.to_v   = expect_to;
        r.pass_v = (r.err == 0) && !expect_to;
        r.fail_v = !r.pass_v;
        res_q.push_back(r);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (i == budget) begin
            checks++; errors++;
            $display("FAIL wait_done: got no done in %0d cycles, expected done", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_counts();
        check("wr_cmds_accepted", wcmd_run, NB);
        check("wr_data_accepted", wdf_run, NB);
        check("rd_cmds_accepted", rcmd_run, NB);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1;
        exp_wa_q.delete(); exp_ra_q.delete(); exp_wd_q.delete(); res_q.delete();
        @(negedge clk) rst = 0;
    endtask

    initial begin
        int de;
        rst = 1; start = 0; calib_done = 0;
        app_if.app_rdy = 0; app_if.app_wdf_rdy = 0;
        app_if.app_rd_data = '0; app_if.app_rd_data_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0); check("rst_done", done, 0);
        check("rst_pass", pass, 0); check("rst_fail", fail, 0);
        check("rst_err", err_count, 0); check("rst_first", first_err_addr, 0);
        check("rst_en", app_if.app_en, 0); check("rst_wren", app_if.app_wdf_wren, 0);
        check("rst_wdf_end", app_if.app_wdf_end, 1); check("rst_mask", app_if.app_wdf_mask, 0);
        @(negedge clk) rst = 0;

        // 1: clean run, calibration arrives 10 cycles after start
        begin_run('0, 0);
        pulse_start();
        repeat (10) @(negedge clk);
        check("busy_waiting_cal", busy, 1);
        calib_done = 1; calib_raised = 1;
        wait_done(500);
        check_counts();
        $display("run1 clean: err=%0d pass=%0d", err_count, pass);

        // 2: 50% stalls, command held until data is 3 bursts ahead, calib drops mid-run
        stall_pct = 50; hold_cmd = 1;
        begin_run('0, 0);
        pulse_start();
        repeat (6) @(negedge clk);
        calib_done = 0;
        wait_done(1000);
        calib_done = 1; hold_cmd = 0;
        check_counts();
        $display("run2 stalls: err=%0d pass=%0d", err_count, pass);

        // 3: bit 5 corrupted on bursts 2 and 3
        stall_pct = 30;
        begin_run(4'b1100, 0);
        pulse_start();
        wait_done(1000);
        check_counts();
        $display("run3 flips: err=%0d first=%0h fail=%0d", err_count, first_err_addr, fail);

        // 4: start after done clears results; clean second run
        begin_run('0, 0);
        pulse_start();
        check("restart_busy", busy, 1); check("restart_done", done, 0);
        check("restart_err", err_count, 0); check("restart_first", first_err_addr, 0);
        check("restart_fail", fail, 0);
        wait_done(1000);
        check_counts();
        $display("run4 restart: err=%0d pass=%0d", err_count, pass);

        // 5: start pulsed during WRITE is ignored
        de = done_events;
        begin_run('0, 0);
        pulse_start();
        for (int i = 0; i < 200 && wcmd_run < 1; i++) @(negedge clk);
        pulse_start();
        wait_done(1000);
        repeat (40) @(negedge clk);
        check("single_run_done_events", done_events - de, 1);
        check("single_run_idle", busy, 0);
        check_counts();
        $display("run5 start-in-write: runs=%0d", done_events - de);

        // 6: reset while two reads are outstanding, then a clean run
        stall_pct = 0; hold_ret = 1;
        begin_run('0, 0);
        pulse_start();
        for (int i = 0; i < 200 && rd_pend.size() < 2; i++) begin
            @(negedge clk);
            #1;
        end
        check("reads_outstanding", rd_pend.size(), 2);
        rst = 1;
        #1;
        check("abort_busy", busy, 0); check("abort_en", app_if.app_en, 0);
        check("abort_err", err_count, 0); check("abort_addr", app_if.app_addr, 0);
        check("abort_done", done, 0); check("abort_wdf_end", app_if.app_wdf_end, 1);
        exp_wa_q.delete(); exp_ra_q.delete(); exp_wd_q.delete(); res_q.delete();
        @(negedge clk);
        @(negedge clk) rst = 0;
        hold_ret = 0; stall_pct = 20;
        begin_run('0, 0);
        pulse_start();
        wait_done(1000);
        check_counts();
        $display("run6 after abort: err=%0d pass=%0d", err_count, pass);

        // 7: reads never return
        hold_ret = 1; stall_pct = 0;
`ifdef MIG_APP_MEMTEST_TIMEOUT_EN
        begin_run('0, 1);
        pulse_start();
        for (int i = 0; i < 400 && !done; i++) @(negedge clk);
        check("timeout_latency_ok", (cyc - last_hs >= 95) && (cyc - last_hs <= 110), 1'b1);
        repeat (3) @(negedge clk);
        $display("run7 watchdog: timeout=%0d fail=%0d after %0d cycles", timeout, fail, cyc - last_hs);
`else
        begin_run('0, 0);
        pulse_start();
        repeat (300) @(negedge clk);
        check("hang_busy", busy, 1); check("hang_timeout", timeout, 0); check("hang_done", done, 0);
        $display("run7 no watchdog: busy=%0d timeout=%0d", busy, timeout);
        do_reset();
`endif
        hold_ret = 0;
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mig_app_memtest.md
Name: mig_app_memtest

Overview:
- Traffic generator and checker that drives the MIG 7-series DDR3 user (app) interface directly upstream of the memory controller.
- On start it writes NUM_BURSTS address-derived bursts, reads them back in order, and compares each against the expected pattern.
- Reports pass/fail, an error count and the first failing address, for LEDs and the UART status path.

Parameters:
- ADDR_W, 29, app_addr width
- DATA_W, 256, app data width; multiple of 32
- NUM_BURSTS, 1024, bursts written then read; ≥1
- ADDR_STEP, 8, app_addr increment per burst (BL8)
- SEED, 32'hA5A5_5A5A, XOR seed for the pattern
- TIMEOUT_CYC, 65535, no-progress limit (optional feature only)

Ports:
- clk  in  1  MIG ui_clk
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; starts a test run
- calib_done  in  1  MIG init_calib_complete
- app_addr  out  ADDR_W  command address
- app_cmd  out  3  3'b000 write, 3'b001 read
- app_en  out  1  command valid
- app_rdy  in  1  command accepted when app_en&app_rdy
- app_wdf_data  out  DATA_W  write data
- app_wdf_wren  out  1  write-data valid
- app_wdf_end  out  1  constant 1
- app_wdf_mask  out  DATA_W/8  constant 0
- app_wdf_rdy  in  1  data accepted when app_wdf_wren&app_wdf_rdy
- app_rd_data  in  DATA_W  read data
- app_rd_data_valid  in  1  read beat valid
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- pass  out  1  done & err_count==0
- fail  out  1  done & (err_count!=0 | timeout)
- err_count  out  16  mismatching bursts; saturates at 16'hFFFF
- first_err_addr  out  ADDR_W  app_addr of first mismatch
- timeout  out  1  watchdog fired

Behaviour:
- Reset: all outputs 0 except app_wdf_end=1. State returns to IDLE. Counters are cleared.
- Reset mid-run aborts immediately; no command completion is awaited.
- Pattern for burst n, 32-bit word k: (n*(DATA_W/32)+k) XOR SEED. Arithmetic is modulo 2^32. Word 0 is in the LSBs.
- Address of burst n: n*ADDR_STEP, truncated to ADDR_W bits (wraps).
- FSM states and transitions:
  - IDLE -> WAIT_CAL on start. Entering WAIT_CAL clears done/pass/fail/err_count/first_err_addr/timeout and sets busy=1.
  - WAIT_CAL -> WRITE when calib_done=1.
  - WRITE: cmd counter and wdf counter advance independently on their own handshakes.
    - app_en/app_cmd=write are held until the handshake; app_addr/app_cmd must not change while app_en&~app_rdy.
    - app_wdf_wren/app_wdf_data are held likewise.
    - Data may lead or trail the command.
    - Each stream deasserts after NUM_BURSTS accepted.
    - -> READ when both counters reach NUM_BURSTS.
  - READ:
    - Issues read commands back-to-back (app_en held, address advances on each accept). Outstanding reads are unlimited.
    - The return counter advances per app_rd_data_valid. Returns are in order; expected data is taken from the return counter.
    - Compare in the same cycle; mismatch registers err_count+1 (saturating) next cycle.
    - first_err_addr is captured on the first mismatch only.
    - -> DONE when return counter == NUM_BURSTS, even if the last accept and the last return occur in the same cycle.
  - DONE: busy=0, done=1, pass/fail set one cycle after entry, then held. -> WAIT_CAL on start.
- start while busy is ignored.
- calib_done falling mid-run is ignored.
- app_rd_data_valid outside READ is ignored.
- Latency: first app_en no earlier than 1 cycle after calib_done is seen high in WAIT_CAL.

Optional Feature:
- MIG_APP_MEMTEST_TIMEOUT_EN defined:
  - A 16-bit counter runs while busy in WRITE or READ. It clears on any cmd, wdf or read-return handshake.
  - On reaching TIMEOUT_CYC: timeout=1, -> DONE with fail=1. Outstanding reads are abandoned.
- Undefined: the counter is absent and timeout is tied 0.

Decomposition:
- Package mig_memtest_pkg holds:
  - state enum (IDLE, WAIT_CAL, WRITE, READ, DONE)
  - CMD_WRITE=3'b000, CMD_READ=3'b001
  - pattern function pat(n, seed)
- Sub-module memtest_pattern_gen: burst index in, DATA_W pattern out; instanced twice (write and expected).

Test Plan:
- NUM_BURSTS=4, ideal memory model, app_rdy/app_wdf_rdy always 1, start while calib_done=0, raise after 10 cycles -> no app_en before calib; 4 writes at addrs 0,8,16,24; word0 of burst1 = 8^A5A55A5A; done=1, pass=1, err_count=0.
- Random app_rdy/app_wdf_rdy stalls (50%), including wdf accepted 3 bursts ahead of cmd -> app_addr/app_wdf_data stable during stall; exactly 4 of each accepted; pass=1.
- Model flips bit 5 of burst 2 and burst 3 read data -> err_count=2, first_err_addr=16, fail=1.
- Assert rst during READ with 2 reads outstanding -> outputs zero next edge; later start runs clean and passes.
- Macro defined, TIMEOUT_CYC=100, model never returns read data -> timeout=1, fail=1 about 100 cycles after the last handshake.
- Macro undefined, same stimulus -> busy stays 1 and timeout=0.
- Pulse start during WRITE -> ignored; single run only.
- Pulse start after done -> results clear, second run passes.
